// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN sample controller.
// Holds the scheduler state enum and mode encodings.
package snn_ctrl_pkg;

  localparam int N_CORE_DEF = 8;

  localparam logic MODE_LERN = 1'b1;
  localparam logic MODE_INFR = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT_INH,
    S_STDP,
    S_WAIT_STDP,
    S_NEXT,
    S_REST,
    S_WAIT_REST,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/done_collector.sv
// Sticky per-core done mask shared by every wait state.
// STEP_WATCHDOG_EN adds a per-wait cycle counter with timeout.
module done_collector
  import snn_ctrl_pkg::*;
#(
  parameter int N_CORE = N_CORE_DEF,
  parameter int WDOG   = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              collect,
  input  logic [N_CORE-1:0] in,
  output logic              all_done,
  output logic              timeout
);

  logic [N_CORE-1:0] mask;

  // Clear wins so bits coincident with an issuing pulse are dropped.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      mask <= '0;
    end else if (collect) begin
      mask <= mask | in;
    end
  end

  assign all_done = &(mask | in);

`ifdef STEP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG + 1);

  logic [WW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (reset || !collect) begin
      wcnt <= '0;
    end else if (!all_done) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign timeout = collect && !all_done
                && (wcnt == WW'(WDOG - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/step_scheduler.sv
// Per-sample timestep sequencer for the 8-core SNN array.
// STEP_WATCHDOG_EN enables the wait watchdog and ERR state.
module step_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter int N_CORE  = N_CORE_DEF,
  parameter int T_STEPS = 350,
  parameter int T_REST  = 150,
  parameter int CNT_W   = 11,
  parameter int WDOG    = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_abort,
  input  logic [N_CORE-1:0] i_inh_valid,
  input  logic [N_CORE-1:0] i_stdp_done,
  output logic              o_cnt_clr,
  output logic              o_run,
  output logic              o_stdp_run,
  output logic              o_rest_run,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_step,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(T_STEPS - 1);
  localparam logic [CNT_W-1:0] REST_LAST =
    CNT_W'((T_REST > 0) ? T_REST - 1 : 0);
  localparam state_t AFTER_RUN =
    (T_REST == 0) ? S_DONE : S_REST;

  state_t            state;
  state_t            nxt;
  logic [CNT_W-1:0]  step;
  logic [CNT_W-1:0]  step_nx;
  logic              mode;
  logic              mode_nx;
  logic              clr;
  logic              collect;
  logic              all_done;
  logic              timeout;
  logic [N_CORE-1:0] done_in;

  assign collect = (state == S_WAIT_INH)
                || (state == S_WAIT_STDP)
                || (state == S_WAIT_REST);

  assign clr = i_abort
            || (state == S_RUN)
            || (state == S_STDP)
            || (state == S_REST);

  assign done_in = (state == S_WAIT_STDP)
                 ? i_stdp_done : i_inh_valid;

  done_collector #(
    .N_CORE (N_CORE),
    .WDOG   (WDOG)
  ) u_coll (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .collect  (collect),
    .in       (done_in),
    .all_done (all_done),
    .timeout  (timeout)
  );

  always_comb begin
    nxt     = state;
    step_nx = step;
    mode_nx = mode;
    if (i_abort) begin
      nxt     = S_IDLE;
      step_nx = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            mode_nx = i_mode;
            nxt     = S_CLR;
          end
        end
        S_CLR: begin
          step_nx = '0;
          nxt     = S_RUN;
        end
        S_RUN: nxt = S_WAIT_INH;
        S_WAIT_INH: begin
          if (all_done) begin
            nxt = (mode == MODE_LERN)
                ? S_STDP : S_NEXT;
          end else if (timeout) begin
            nxt = S_ERR;
          end
        end
        S_STDP: nxt = S_WAIT_STDP;
        S_WAIT_STDP: begin
          if (all_done) begin
            nxt = S_NEXT;
          end else if (timeout) begin
            nxt = S_ERR;
          end
        end
        S_NEXT: begin
          if (step == RUN_LAST) begin
            step_nx = '0;
            nxt     = AFTER_RUN;
          end else begin
            step_nx = step + 1'b1;
            nxt     = S_RUN;
          end
        end
        S_REST: nxt = S_WAIT_REST;
        S_WAIT_REST: begin
          if (all_done) begin
            if (step == REST_LAST) begin
              nxt = S_DONE;
            end else begin
              step_nx = step + 1'b1;
              nxt     = S_REST;
            end
          end else if (timeout) begin
            nxt = S_ERR;
          end
        end
        S_DONE: nxt = S_IDLE;
        S_ERR:  nxt = S_ERR;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Pulses are decoded from the next state so they leave a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      step       <= '0;
      mode       <= MODE_INFR;
      o_cnt_clr  <= 1'b0;
      o_run      <= 1'b0;
      o_stdp_run <= 1'b0;
      o_rest_run <= 1'b0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= nxt;
      step       <= step_nx;
      mode       <= mode_nx;
      o_cnt_clr  <= (nxt == S_CLR);
      o_run      <= (nxt == S_RUN);
      o_stdp_run <= (nxt == S_STDP);
      o_rest_run <= (nxt == S_REST);
      o_done     <= (nxt == S_DONE);
      o_busy     <= (nxt != S_IDLE);
    end
  end

  assign o_step = step;

`ifdef STEP_WATCHDOG_EN
  logic err;

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (nxt == S_ERR) begin
      err <= 1'b1;
    end else if ((state == S_IDLE) && i_start
                 && !i_abort) begin
      err <= 1'b0;
    end
  end

  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Randomized bench for step_scheduler against an event-timing model.
// Watchdog checks run only when STEP_WATCHDOG_EN is defined.
module tb_step_scheduler;

  localparam int NC = 8;
  localparam int TS = 4;
  localparam int TR = 2;
  localparam int CW = 11;
  localparam int WD = 20;

  localparam int K_CLR  = 0;
  localparam int K_RUN  = 1;
  localparam int K_STDP = 2;
  localparam int K_REST = 3;
  localparam int K_DONE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic          i_mode;
  logic          i_abort;
  logic [NC-1:0] i_inh_valid;
  logic [NC-1:0] i_stdp_done;
  logic          o_cnt_clr;
  logic          o_run;
  logic          o_stdp_run;
  logic          o_rest_run;
  logic          o_busy;
  logic          o_done;
  logic [CW-1:0] o_step;
  logic          o_err;

  step_scheduler #(
    .N_CORE  (NC),
    .T_STEPS (TS),
    .T_REST  (TR),
    .CNT_W   (CW),
    .WDOG    (WD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_abort     (i_abort),
    .i_inh_valid (i_inh_valid),
    .i_stdp_done (i_stdp_done),
    .o_cnt_clr   (o_cnt_clr),
    .o_run       (o_run),
    .o_stdp_run  (o_stdp_run),
    .o_rest_run  (o_rest_run),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_step      (o_step),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int t;
    int step;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  dly[NC];
  bit  silent[NC];
  bit  dup0 = 0;
  bit  coinc5 = 0;
  int  run_seen = 0;
  int  inh_t[$];
  int  inh_c[$];
  int  sd_t[$];
  int  sd_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0d, expected %0d",
             tag, got, want);
    end
  endtask

  // Core responder and output-pulse monitor.
  initial begin
    i_inh_valid = '0;
    i_stdp_done = '0;
    forever begin
      logic [NC-1:0] v;
      @(negedge clk);
      if (o_cnt_clr) begin
        obs.push_back('{K_CLR, cyc, -1});
        run_seen = 0;
      end
      if (o_run || o_rest_run) begin
        if (o_run)
          obs.push_back('{K_RUN, cyc, int'(o_step)});
        else
          obs.push_back('{K_REST, cyc, int'(o_step)});
        for (int c = 0; c < NC; c++) begin
          if (silent[c]) continue;
          if (o_run && coinc5 && c == 5
              && run_seen == 0) begin
            inh_t.push_back(cyc);
            inh_c.push_back(c);
            inh_t.push_back(cyc + 7);
            inh_c.push_back(c);
          end else begin
            inh_t.push_back(cyc + dly[c]);
            inh_c.push_back(c);
          end
        end
        if (dup0 && !silent[0]) begin
          inh_t.push_back(cyc + dly[0] + 1);
          inh_c.push_back(0);
        end
        if (o_run) run_seen++;
      end
      if (o_stdp_run) begin
        obs.push_back('{K_STDP, cyc, int'(o_step)});
        for (int c = 0; c < NC; c++) begin
          if (silent[c]) continue;
          sd_t.push_back(cyc + dly[c]);
          sd_c.push_back(c);
        end
      end
      if (o_done) obs.push_back('{K_DONE, cyc, -1});
      v = '0;
      for (int k = inh_t.size() - 1; k >= 0; k--)
        if (inh_t[k] <= cyc) begin
          v[inh_c[k]] = 1'b1;
          inh_t.delete(k);
          inh_c.delete(k);
        end
      i_inh_valid = v;
      v = '0;
      for (int k = sd_t.size() - 1; k >= 0; k--)
        if (sd_t[k] <= cyc) begin
          v[sd_c[k]] = 1'b1;
          sd_t.delete(k);
          sd_c.delete(k);
        end
      i_stdp_done = v;
    end
  end

  task automatic clear_sched();
    inh_t.delete();
    inh_c.delete();
    sd_t.delete();
    sd_c.delete();
  endtask

  // Expected pulse schedule derived from the timing rules.
  task automatic build_exp(input int n, input bit learn,
                           input int d, input int d0);
    int t;
    int k;
    exp_q.delete();
    exp_q.push_back('{K_CLR, n + 1, -1});
    t = n + 2;
    for (int s = 0; s < TS; s++) begin
      exp_q.push_back('{K_RUN, t, s});
      k = t + ((s == 0) ? d0 : d);
      if (learn) begin
        exp_q.push_back('{K_STDP, k + 1, s});
        t = k + 1 + d + 2;
      end else begin
        t = k + 2;
      end
    end
    for (int r = 0; r < TR; r++) begin
      exp_q.push_back('{K_REST, t, r});
      t = t + d + 1;
    end
    exp_q.push_back('{K_DONE, t, -1});
  endtask

  task automatic start_sample(input bit learn,
                              output int n);
    obs.delete();
    @(posedge clk); #1;
    n = cyc;
    i_mode = learn;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_mode = 1'($urandom);
    chk("err_after_start", o_err, 0);
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic run_sample(input bit learn, input int d0,
                            input bit spurious);
    int n;
    int d;
    int hit;
    int m;
    d = 0;
    for (int c = 0; c < NC; c++)
      if (dly[c] > d) d = dly[c];
    if (d0 == 0) d0 = d;
    start_sample(learn, n);
    build_exp(n, learn, d, d0);
    hit = 0;
    for (int k = 0; k < 3000 && hit == 0; k++) begin
      @(posedge clk); #1;
      i_start = (spurious && k == 8);
      if (obs.size() > 0 && obs[$].kind == K_DONE)
        hit = 1;
    end
    i_start = 1'b0;
    chk("sample_end", hit, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_idle", o_busy, 0);
    chk("ev_count", obs.size(), exp_q.size());
    m = (obs.size() < exp_q.size())
      ? obs.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk("ev_kind", obs[k].kind, exp_q[k].kind);
      chk("ev_time", obs[k].t - n, exp_q[k].t - n);
      if (exp_q[k].step >= 0)
        chk("ev_step", obs[k].step, exp_q[k].step);
    end
  endtask

  task automatic set_dly(input int v);
    for (int c = 0; c < NC; c++) dly[c] = v;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {o_cnt_clr, o_run, o_stdp_run,
              o_rest_run, o_done, o_busy,
              o_err, o_step}, 0);
  endtask

  task automatic count_done(input string tag);
    int nd;
    repeat (30) @(posedge clk);
    #1;
    nd = 0;
    foreach (obs[k]) if (obs[k].kind == K_DONE) nd++;
    chk(tag, nd, 0);
  endtask

  initial begin
    int n;
    int hit;
    int t_run;
    reset = 1'b1;
    i_start = 1'b0;
    i_mode = 1'b0;
    i_abort = 1'b0;
    for (int c = 0; c < NC; c++) silent[c] = 0;
    set_dly(3);
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset_outputs");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_quiet("idle_outputs");

    run_sample(1'b0, 0, 1'b0);
    run_sample(1'b1, 0, 1'b0);

    for (int c = 0; c < 7; c++) dly[c] = c + 1;
    dly[7] = 10;
    dup0 = 1;
    run_sample(1'b0, 0, 1'b0);
    dup0 = 0;

    set_dly(2);
    coinc5 = 1;
    run_sample(1'b0, 7, 1'b0);
    coinc5 = 0;

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NC; c++)
        dly[c] = $urandom_range(1, 6);
      run_sample(1'($urandom), 0, r == 1);
    end

    // Abort while the STDP wait is open.
    set_dly(2);
    start_sample(1'b1, n);
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      @(posedge clk); #1;
      foreach (obs[j]) if (obs[j].kind == K_STDP) hit = 1;
    end
    chk("stdp_seen", hit, 1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk_quiet("abort_outputs");
    clear_sched();
    count_done("abort_no_done");

    // Reset in the middle of the rest phase.
    start_sample(1'b0, n);
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      @(posedge clk); #1;
      foreach (obs[j]) if (obs[j].kind == K_REST) hit = 1;
    end
    chk("rest_seen", hit, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_quiet("midreset_outputs");
    clear_sched();
    count_done("reset_no_done");

    run_sample(1'b1, 0, 1'b0);

`ifdef STEP_WATCHDOG_EN
    silent[3] = 1;
    start_sample(1'b0, n);
    t_run = n + 2;
    hit = -1;
    for (int k = 0; k < 100 && hit < 0; k++) begin
      @(posedge clk); #1;
      if (o_err === 1'b1) hit = cyc;
    end
    chk("wdog_time", hit - t_run, WD + 1);
    chk("wdog_busy", o_busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", o_err, 1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("err_abort_busy", o_busy, 0);
    chk("err_after_abort", o_err, 1);
    clear_sched();
    silent[3] = 0;
    repeat (10) @(posedge clk);
    run_sample(1'b0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
